// File: rtl/othello_pkg.sv
// Shared Othello board definitions: cell codes, board geometry, direction
// offsets, colour helpers and the disc flipper state encoding.
package othello_pkg;

    typedef enum logic [1:0] {
        CELL_EMPTY  = 2'b00,
        CELL_BLACK  = 2'b01,
        CELL_WHITE  = 2'b10,
        CELL_BORDER = 2'b11
    } cell_t;

    localparam int BOARD_W = 10;
    localparam int ADDR_W  = 7;
    localparam int STEP_W  = 5;

    // Offsets on the 10-wide board; the border ring stops every walk.
    localparam logic signed [STEP_W-1:0] DIR_N  = -5'sd10;
    localparam logic signed [STEP_W-1:0] DIR_NE = -5'sd9;
    localparam logic signed [STEP_W-1:0] DIR_E  =  5'sd1;
    localparam logic signed [STEP_W-1:0] DIR_SE =  5'sd11;
    localparam logic signed [STEP_W-1:0] DIR_S  =  5'sd10;
    localparam logic signed [STEP_W-1:0] DIR_SW =  5'sd9;
    localparam logic signed [STEP_W-1:0] DIR_W  = -5'sd1;
    localparam logic signed [STEP_W-1:0] DIR_NW = -5'sd11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PLACE   = 3'd1,
        ST_ADVANCE = 3'd2,
        ST_WAIT    = 3'd3,
        ST_CHECK   = 3'd4,
        ST_FLIP    = 3'd5,
        ST_DONE    = 3'd6
    } flip_state_t;

    function automatic logic [1:0] own_colour(input logic player);
        if (player) return CELL_WHITE;
        else        return CELL_BLACK;
    endfunction

    function automatic logic [1:0] opp_colour(input logic player);
        if (player) return CELL_BLACK;
        else        return CELL_WHITE;
    endfunction

endpackage

// File: rtl/othello_addr_step.sv
// Next board address along a direction: cur + sign-extended step, wrapping
// modulo 2^ADDR_W.
module othello_addr_step #(
    parameter int ADDR_W = 7,
    parameter int STEP_W = 5
) (
    input  logic [ADDR_W-1:0] i_cur,
    input  logic [STEP_W-1:0] i_step,
    output logic [ADDR_W-1:0] o_next
);

    assign o_next = i_cur + {{(ADDR_W-STEP_W){i_step[STEP_W-1]}}, i_step};

endmodule

// File: rtl/disc_flipper.sv
// Walks the board RAM from a placed disc along one direction, rewriting
// opponent discs with the mover's colour until an own disc ends the run.
module disc_flipper #(
    parameter int ADDR_W  = othello_pkg::ADDR_W,
    parameter int STEP_W  = othello_pkg::STEP_W,
    parameter int RD_LAT  = 1,
    parameter int MAX_RUN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] s_addr_in,
    input  logic [STEP_W-1:0] step_in,
    input  logic              player,
    input  logic              place_en,
    input  logic [1:0]        data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic              wren_o,
    output logic [1:0]        data_out,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [3:0]        flip_cnt_o
);
    import othello_pkg::*;

    localparam logic [3:0] RUN_LAST  = 4'(MAX_RUN);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);

    flip_state_t       r_state;
    logic [ADDR_W-1:0] r_cur;
    logic [ADDR_W-1:0] r_addr;
    logic [STEP_W-1:0] r_step;
    logic [1:0]        r_own;
    logic [1:0]        r_opp;
    logic [1:0]        r_data;
    logic [3:0]        r_run;
    logic [3:0]        r_flip_cnt;
    logic [1:0]        r_wait;
    logic              r_wren;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] w_base;
    logic [STEP_W-1:0] w_step;
    logic [ADDR_W-1:0] w_next;

    // In IDLE the first cell is computed directly from the request inputs
    always_comb begin
        w_base = r_cur;
        w_step = r_step;
        if (r_state == ST_IDLE) begin
            w_base = s_addr_in;
            w_step = step_in;
        end else begin
            w_base = r_cur;
            w_step = r_step;
        end
    end

    othello_addr_step #(
        .ADDR_W (ADDR_W),
        .STEP_W (STEP_W)
    ) u_addr_step (
        .i_cur  (w_base),
        .i_step (w_step),
        .o_next (w_next)
    );

    // Walk FSM; every output is registered on the transition into its state
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_cur      <= '0;
            r_addr     <= '0;
            r_step     <= '0;
            r_own      <= 2'b00;
            r_opp      <= 2'b00;
            r_data     <= 2'b00;
            r_run      <= 4'd0;
            r_flip_cnt <= 4'd0;
            r_wait     <= 2'd0;
            r_wren     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_wren <= 1'b0;
                    r_done <= 1'b0;
                    if (start) begin
                        r_step     <= step_in;
                        r_own      <= own_colour(player);
                        r_opp      <= opp_colour(player);
                        r_data     <= own_colour(player);
                        r_flip_cnt <= 4'd0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        if (place_en) begin
                            r_state <= ST_PLACE;
                            r_cur   <= s_addr_in;
                            r_addr  <= s_addr_in;
                            r_wren  <= 1'b1;
                            r_run   <= 4'd0;
                        end else begin
                            r_state <= ST_ADVANCE;
                            r_cur   <= w_next;
                            r_addr  <= w_next;
                            r_run   <= 4'd1;
                        end
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_PLACE, ST_FLIP: begin
                    r_state <= ST_ADVANCE;
                    r_wren  <= 1'b0;
                    r_cur   <= w_next;
                    r_addr  <= w_next;
                    r_run   <= r_run + 4'd1;
                end
                ST_ADVANCE: begin
                    r_state <= ST_WAIT;
                    r_wait  <= 2'd0;
                end
                ST_WAIT: begin
                    if (r_wait == WAIT_LAST) begin
                        r_state <= ST_CHECK;
                    end else begin
                        r_wait <= r_wait + 2'd1;
                    end
                end
                ST_CHECK: begin
                    // An opponent disc on the last allowed cell cannot be bracketed
                    if ((data_in == r_opp) && (r_run < RUN_LAST)) begin
                        r_state <= ST_FLIP;
                        r_wren  <= 1'b1;
                        if (r_flip_cnt != 4'd15) begin
                            r_flip_cnt <= r_flip_cnt + 4'd1;
                        end else begin
                            r_flip_cnt <= r_flip_cnt;
                        end
                    end else begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_err   <= (data_in == r_own) ? 1'b0 : 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_wren  <= 1'b0;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign addr_out   = r_addr;
    assign wren_o     = r_wren;
    assign data_out   = r_data;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign flip_cnt_o = r_flip_cnt;

endmodule

// File: tb/tb_disc_flipper.sv
// Scoreboard bench: two flippers (read latency 1 and 2) share the request
// inputs, each with its own board RAM; a board-walk model predicts writes.
module tb_disc_flipper;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [6:0] s_addr;
    logic [4:0] step;
    logic       player;
    logic       place_en;

    logic [1:0] data_in  [2];
    logic [6:0] addr_o   [2];
    logic       wren_o   [2];
    logic [1:0] data_o   [2];
    logic       busy_o   [2];
    logic       done_o   [2];
    logic       err_o    [2];
    logic [3:0] flip_o   [2];

    typedef struct { int err; int cnt; int lat; } done_t;

    int         total = 0;
    int         bad   = 0;
    logic [1:0] mem   [2][128];
    logic [1:0] board [128];
    logic [1:0] exp_b [128];
    logic [1:0] rd1   [2];
    logic [1:0] rd2   [2];
    int         wq    [2][$];
    done_t      dq    [2][$];
    int         bcnt  [2];
    int         dcnt  [2];
    int         exp_n;

    always #5 clock = ~clock;

    disc_flipper #(.RD_LAT(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start), .s_addr_in(s_addr),
        .step_in(step), .player(player), .place_en(place_en), .data_in(data_in[0]),
        .addr_out(addr_o[0]), .wren_o(wren_o[0]), .data_out(data_o[0]),
        .busy_o(busy_o[0]), .done_o(done_o[0]), .err_o(err_o[0]), .flip_cnt_o(flip_o[0])
    );

    disc_flipper #(.RD_LAT(2)) u_dut2 (
        .clock(clock), .reset(reset), .start(start), .s_addr_in(s_addr),
        .step_in(step), .player(player), .place_en(place_en), .data_in(data_in[1]),
        .addr_out(addr_o[1]), .wren_o(wren_o[1]), .data_out(data_o[1]),
        .busy_o(busy_o[1]), .done_o(done_o[1]), .err_o(err_o[1]), .flip_cnt_o(flip_o[1])
    );

    // Board RAMs: synchronous read pipelined to each lane's latency
    always @(posedge clock) begin
        for (int l = 0; l < 2; l++) begin
            rd1[l] <= mem[l][addr_o[l]];
            rd2[l] <= rd1[l];
            if (wren_o[l]) mem[l][addr_o[l]] = data_o[l];
        end
    end
    assign data_in[0] = rd1[0];
    assign data_in[1] = rd2[1];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: pops expected writes and done records as the DUTs present them
    always @(negedge clock) begin
        for (int l = 0; l < 2; l++) begin
            if (reset) begin
                if (busy_o[l]) bcnt[l]++;
                if (wren_o[l]) begin
                    if (wq[l].size() == 0) begin
                        chk($sformatf("unexpected_write_lane%0d", l), int'({addr_o[l], data_o[l]}), -1);
                    end else begin
                        chk($sformatf("write_lane%0d", l), int'({addr_o[l], data_o[l]}), wq[l].pop_front());
                    end
                end
                if (done_o[l]) begin
                    if (dq[l].size() == 0) begin
                        chk($sformatf("unexpected_done_lane%0d", l), 1, 0);
                    end else begin
                        done_t d;
                        d = dq[l].pop_front();
                        chk($sformatf("err_lane%0d", l), int'(err_o[l]), d.err);
                        chk($sformatf("flip_cnt_lane%0d", l), int'(flip_o[l]), d.cnt);
                        chk($sformatf("latency_lane%0d", l), bcnt[l], d.lat);
                    end
                    dcnt[l]++;
                end
            end
        end
    end

    function automatic bit interior(input int p);
        return (p / 10 >= 1) && (p / 10 <= 8) && (p % 10 >= 1) && (p % 10 <= 8);
    endfunction

    task automatic clear_board();
        for (int a = 0; a < 128; a++) board[a] = interior(a) ? 2'b00 : 2'b11;
    endtask

    // Reference: walk the board by the game rules and queue the expected results
    task automatic predict(input int s, input int st, input int pl, input int pe);
        int own, opp, pos, k, n, err, c;
        int w[$];
        own = pl ? 2 : 1;
        opp = pl ? 1 : 2;
        for (int a = 0; a < 128; a++) exp_b[a] = board[a];
        n = 0; k = 0; err = 1; pos = s;
        if (pe != 0) begin
            exp_b[s] = 2'(own);
            w.push_back(s * 4 + own);
        end
        for (int i = 1; i <= 8; i++) begin
            pos = (pos + st) & 127;
            k = i;
            c = int'(exp_b[pos]);
            if (c == opp && i < 8) begin
                exp_b[pos] = 2'(own);
                n++;
                w.push_back(pos * 4 + own);
            end else begin
                err = (c == own) ? 0 : 1;
                break;
            end
        end
        exp_n = n;
        for (int l = 0; l < 2; l++) begin
            done_t d;
            foreach (w[i]) wq[l].push_back(w[i]);
            d.err = err;
            d.cnt = (n > 15) ? 15 : n;
            d.lat = pe + k * (2 + l + 1) + n + 1;
            dq[l].push_back(d);
            for (int a = 0; a < 128; a++) mem[l][a] = board[a];
            bcnt[l] = 0;
        end
    endtask

    task automatic run(input string nm, input int s, input int st, input int pl,
                       input int pe, input bit dup);
        int d0, d1, cyc, diff;
        @(negedge clock);
        predict(s, st, pl, pe);
        d0 = dcnt[0];
        d1 = dcnt[1];
        s_addr = 7'(s); step = 5'(st); player = pl[0]; place_en = pe[0]; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        if (dup) begin
            @(negedge clock);
            s_addr = 7'd11; step = 5'd1; player = ~player; place_en = 1'b1; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        cyc = 0;
        while (cyc < 200 && (dcnt[0] == d0 || dcnt[1] == d1)) begin
            @(negedge clock);
            cyc++;
        end
        if (cyc >= 200) chk({nm, "_timeout"}, cyc, 0);
        repeat (4) @(negedge clock);
        for (int l = 0; l < 2; l++) begin
            diff = 0;
            for (int a = 0; a < 128; a++) if (mem[l][a] !== exp_b[a]) diff++;
            chk($sformatf("%s_board_lane%0d", nm, l), diff, 0);
            chk($sformatf("%s_done_pulses_lane%0d", nm, l), dcnt[l] - (l == 0 ? d0 : d1), 1);
            chk($sformatf("%s_writes_left_lane%0d", nm, l), wq[l].size(), 0);
            chk($sformatf("%s_flip_held_lane%0d", nm, l), int'(flip_o[l]), exp_n);
            chk($sformatf("%s_idle_lane%0d", nm, l), int'(busy_o[l]), 0);
        end
    endtask

    initial begin
        int s, st, pl, pe, r, p;
        int dirs[8] = '{-10, -9, 1, 11, 10, 9, -1, -11};
        reset = 1'b0; start = 1'b0; s_addr = 7'd0; step = 5'd0; player = 1'b0; place_en = 1'b0;
        for (int l = 0; l < 2; l++) begin bcnt[l] = 0; dcnt[l] = 0; end
        clear_board();
        for (int l = 0; l < 2; l++) for (int a = 0; a < 128; a++) mem[l][a] = board[a];
        repeat (3) @(negedge clock);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("reset_outputs_lane%0d", l),
                int'({addr_o[l], wren_o[l], data_o[l], busy_o[l], done_o[l], err_o[l], flip_o[l]}), 0);
        end
        reset = 1'b1;

        clear_board(); board[35] = 2'b10; board[36] = 2'b10; board[37] = 2'b01;
        run("black_east_place", 34, 1, 0, 1, 1'b0);
        clear_board(); board[35] = 2'b01; board[25] = 2'b10;
        run("white_north", 45, -10, 1, 0, 1'b0);
        clear_board(); board[45] = 2'b10; board[56] = 2'b00;
        run("black_se_empty", 34, 11, 0, 0, 1'b0);
        clear_board();
        run("into_border", 18, 1, 0, 0, 1'b0);
        clear_board(); board[35] = 2'b10; board[36] = 2'b10; board[37] = 2'b01;
        run("start_while_busy", 34, 1, 0, 1, 1'b1);

        // Reset while lane 0 is rewriting cell 35
        clear_board(); board[35] = 2'b10; board[36] = 2'b10; board[37] = 2'b01;
        @(negedge clock);
        predict(34, 1, 0, 1);
        s_addr = 7'd34; step = 5'd1; player = 1'b0; place_en = 1'b1; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        r = 0;
        while (r < 50 && !(wren_o[0] && addr_o[0] == 7'd35)) begin
            @(negedge clock);
            r++;
        end
        if (r >= 50) chk("reset_mid_flip_reach", r, 0);
        reset = 1'b0;
        @(negedge clock);
        for (int l = 0; l < 2; l++) begin
            chk($sformatf("reset_mid_flip_lane%0d", l),
                int'({wren_o[l], busy_o[l], done_o[l], flip_o[l]}), 0);
            wq[l].delete();
            dq[l].delete();
        end
        reset = 1'b1;
        clear_board(); board[35] = 2'b01; board[25] = 2'b10;
        run("after_reset", 45, -10, 1, 0, 1'b0);

        for (int t = 0; t < 40; t++) begin
            clear_board();
            for (int a = 0; a < 128; a++) if (interior(a)) board[a] = 2'($urandom_range(0, 2));
            s  = 10 * $urandom_range(1, 8) + $urandom_range(1, 8);
            st = dirs[$urandom_range(0, 7)];
            pl = $urandom_range(0, 1);
            pe = $urandom_range(0, 1);
            r  = $urandom_range(0, 6);
            p  = s;
            for (int i = 0; i < r; i++) begin
                p = p + st;
                if (interior(p)) board[p] = (pl != 0) ? 2'b01 : 2'b10;
            end
            run($sformatf("rand%0d", t), s, st, pl, pe, ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
